// File: rtl/monitor_rr_stats_if.sv
// Valid/ready bundle carrying DUT operand/result triples into the round-robin monitor.
interface monitor_rr_stats_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_dut_ia;
  logic [WIDTH-1:0] i_dut_ib;
  logic [WIDTH-1:0] i_dut_os;

  modport master (output i_valid, i_dut_ia, i_dut_ib, i_dut_os, input o_ready);
  modport slave  (input i_valid, i_dut_ia, i_dut_ib, i_dut_os, output o_ready);
endinterface

// File: rtl/monitor_rr_stats.sv
// Round-robin result monitor: spreads DUT triples over NUM_SUB_MON adder-model lanes,
// compares each lane two cycles after loading and keeps mismatch statistics.
module monitor_rr_stats #(
  parameter int WIDTH       = 32,
  parameter int NUM_SUB_MON = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  monitor_rr_stats_if.slave    bus,
  input  logic                 i_clear,
  output logic                 o_event,
  output logic                 o_err_sticky,
  output logic [CNT_W-1:0]     o_txn_count,
  output logic [CNT_W-1:0]     o_err_count,
  output logic                 o_cap_valid,
  output logic [WIDTH-1:0]     o_cap_a,
  output logic [WIDTH-1:0]     o_cap_b,
  output logic [WIDTH-1:0]     o_cap_dut,
  output logic [WIDTH-1:0]     o_cap_exp
);

  typedef logic [WIDTH-1:0] word_t;

  logic [NUM_SUB_MON-1:0] r_ptr;
  logic [NUM_SUB_MON-1:0] r_busy;
  logic [NUM_SUB_MON-1:0] r_stb;
  word_t                  r_a   [NUM_SUB_MON];
  word_t                  r_b   [NUM_SUB_MON];
  word_t                  r_dut [NUM_SUB_MON];
  word_t                  r_mon [NUM_SUB_MON];

  logic                   w_xfer;
  logic [NUM_SUB_MON-1:0] w_load;
  logic [NUM_SUB_MON-1:0] w_ptr_rot;
  logic                   w_cmp;
  logic                   w_mis;
  word_t                  w_sel_a;
  word_t                  w_sel_b;
  word_t                  w_sel_dut;
  word_t                  w_sel_mon;

  // The pointed lane is only unavailable if it was loaded on the previous edge.
  assign bus.o_ready = ~|(r_ptr & r_busy);
  assign w_xfer      = bus.i_valid & bus.o_ready;
  assign w_load      = r_ptr & {NUM_SUB_MON{w_xfer}};

  generate
    if (NUM_SUB_MON == 1) begin : g_one_lane
      assign w_ptr_rot = r_ptr;
    end else begin : g_many_lanes
      assign w_ptr_rot = {r_ptr[NUM_SUB_MON-2:0], r_ptr[NUM_SUB_MON-1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= NUM_SUB_MON'(1);
      r_busy <= '0;
      r_stb  <= '0;
    end else begin
      if (w_xfer) begin
        r_ptr <= w_ptr_rot;
      end
      r_busy <= w_load;
      r_stb  <= r_busy;
    end
  end

  // Model stage runs one edge after load, so the compare two edges after load sees a settled result.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SUB_MON; i++) begin
      if (w_load[i]) begin
        r_a[i]   <= bus.i_dut_ia;
        r_b[i]   <= bus.i_dut_ib;
        r_dut[i] <= bus.i_dut_os;
      end
      if (r_busy[i]) begin
        r_mon[i] <= r_a[i] + r_b[i];
      end
    end
  end

  always_comb begin
    w_cmp     = 1'b0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_dut = '0;
    w_sel_mon = '0;
    for (int i = 0; i < NUM_SUB_MON; i++) begin
      if (r_stb[i]) begin
        w_cmp     = 1'b1;
        w_sel_a   = r_a[i];
        w_sel_b   = r_b[i];
        w_sel_dut = r_dut[i];
        w_sel_mon = r_mon[i];
      end
    end
  end

  assign w_mis = w_cmp && (w_sel_dut != w_sel_mon);

  // A clear in the same cycle as a compare wins, so that compare never reaches the stats.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      o_event      <= 1'b0;
      o_err_sticky <= 1'b0;
      o_txn_count  <= '0;
      o_err_count  <= '0;
      o_cap_valid  <= 1'b0;
      o_cap_a      <= '0;
      o_cap_b      <= '0;
      o_cap_dut    <= '0;
      o_cap_exp    <= '0;
    end else begin
      o_event <= w_mis;
      if (w_cmp && (o_txn_count != '1)) begin
        o_txn_count <= o_txn_count + CNT_W'(1);
      end
      if (w_mis) begin
        if (o_err_count != '1) begin
          o_err_count <= o_err_count + CNT_W'(1);
        end
        if (!o_cap_valid) begin
          o_cap_valid  <= 1'b1;
          o_err_sticky <= 1'b1;
          o_cap_a      <= w_sel_a;
          o_cap_b      <= w_sel_b;
          o_cap_dut    <= w_sel_dut;
          o_cap_exp    <= w_sel_mon;
        end
      end
    end
  end

endmodule

// File: tb/tb_monitor_rr_stats.sv
// Four monitor configurations (2/1/4 lanes, plus a 2-bit counter variant) share one stimulus
// stream; each is checked against a transaction-level model of the monitor's rules.
module tb_monitor_rr_stats;

  localparam int W = 32;
  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, clr, valid;
  logic [W-1:0] a, b, os;

  logic         rdy    [ND];
  logic         ev     [ND];
  logic         sticky [ND];
  logic         capv   [ND];
  logic [15:0]  txn    [ND];
  logic [15:0]  err    [ND];
  logic [W-1:0] capa   [ND];
  logic [W-1:0] capb   [ND];
  logic [W-1:0] capd   [ND];
  logic [W-1:0] cape   [ND];
  logic [1:0]   txn3, err3;

  int checks = 0;
  int errors = 0;

  monitor_rr_stats_if #(.WIDTH(W)) bus0 ();
  monitor_rr_stats_if #(.WIDTH(W)) bus1 ();
  monitor_rr_stats_if #(.WIDTH(W)) bus2 ();
  monitor_rr_stats_if #(.WIDTH(W)) bus3 ();

  assign bus0.i_valid = valid; assign bus0.i_dut_ia = a; assign bus0.i_dut_ib = b; assign bus0.i_dut_os = os;
  assign bus1.i_valid = valid; assign bus1.i_dut_ia = a; assign bus1.i_dut_ib = b; assign bus1.i_dut_os = os;
  assign bus2.i_valid = valid; assign bus2.i_dut_ia = a; assign bus2.i_dut_ib = b; assign bus2.i_dut_os = os;
  assign bus3.i_valid = valid; assign bus3.i_dut_ia = a; assign bus3.i_dut_ib = b; assign bus3.i_dut_os = os;
  assign rdy[0] = bus0.o_ready;
  assign rdy[1] = bus1.o_ready;
  assign rdy[2] = bus2.o_ready;
  assign rdy[3] = bus3.o_ready;
  assign txn[3] = {14'd0, txn3};
  assign err[3] = {14'd0, err3};

  monitor_rr_stats #(.WIDTH(W), .NUM_SUB_MON(2), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0), .i_clear(clr), .o_event(ev[0]), .o_err_sticky(sticky[0]),
    .o_txn_count(txn[0]), .o_err_count(err[0]), .o_cap_valid(capv[0]), .o_cap_a(capa[0]),
    .o_cap_b(capb[0]), .o_cap_dut(capd[0]), .o_cap_exp(cape[0]));
  monitor_rr_stats #(.WIDTH(W), .NUM_SUB_MON(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1), .i_clear(clr), .o_event(ev[1]), .o_err_sticky(sticky[1]),
    .o_txn_count(txn[1]), .o_err_count(err[1]), .o_cap_valid(capv[1]), .o_cap_a(capa[1]),
    .o_cap_b(capb[1]), .o_cap_dut(capd[1]), .o_cap_exp(cape[1]));
  monitor_rr_stats #(.WIDTH(W), .NUM_SUB_MON(4), .CNT_W(16)) dut2 (
    .clk(clk), .reset(rst), .bus(bus2), .i_clear(clr), .o_event(ev[2]), .o_err_sticky(sticky[2]),
    .o_txn_count(txn[2]), .o_err_count(err[2]), .o_cap_valid(capv[2]), .o_cap_a(capa[2]),
    .o_cap_b(capb[2]), .o_cap_dut(capd[2]), .o_cap_exp(cape[2]));
  monitor_rr_stats #(.WIDTH(W), .NUM_SUB_MON(2), .CNT_W(2)) dut3 (
    .clk(clk), .reset(rst), .bus(bus3), .i_clear(clr), .o_event(ev[3]), .o_err_sticky(sticky[3]),
    .o_txn_count(txn3), .o_err_count(err3), .o_cap_valid(capv[3]), .o_cap_a(capa[3]),
    .o_cap_b(capb[3]), .o_cap_dut(capd[3]), .o_cap_exp(cape[3]));

  // Transaction-level model: every accepted triple resolves exactly two edges later.
  typedef struct packed {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] os;
  } txn_t;

  txn_t         h1 [ND];
  txn_t         h2 [ND];
  int           nlanes [ND] = '{2, 1, 4, 2};
  int unsigned  satv   [ND] = '{65535, 65535, 65535, 3};
  bit           m_ready [ND];
  bit           m_ev    [ND];
  bit           m_capv  [ND];
  int unsigned  m_txn   [ND];
  int unsigned  m_err   [ND];
  logic [W-1:0] m_capa [ND];
  logic [W-1:0] m_capb [ND];
  logic [W-1:0] m_capd [ND];
  logic [W-1:0] m_cape [ND];
  int           acc_cnt [ND];
  int           ev_seen [ND];

  task automatic step(input bit v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [W-1:0] ios, input bit c, input bit r);
    bit           acc [ND];
    txn_t         done;
    logic [W-1:0] expv;
    valid = v; a = ia; b = ib; os = ios; clr = c; rst = r;
    for (int d = 0; d < ND; d++) acc[d] = v && m_ready[d] && !r;
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      ev_seen[d] += int'(ev[d]);
      m_ev[d] = 1'b0;
      if (r || c) begin
        m_txn[d] = 0; m_err[d] = 0; m_capv[d] = 1'b0;
        m_capa[d] = '0; m_capb[d] = '0; m_capd[d] = '0; m_cape[d] = '0;
      end
      if (r) begin
        h1[d] = '0; h2[d] = '0; m_ready[d] = 1'b1;
      end else begin
        done  = h2[d];
        h2[d] = h1[d];
        h1[d] = acc[d] ? {1'b1, ia, ib, ios} : '0;
        if (acc[d]) acc_cnt[d]++;
        m_ready[d] = !(acc[d] && nlanes[d] == 1);
        if (!c && done.v) begin
          expv = done.a + done.b;
          if (m_txn[d] < satv[d]) m_txn[d]++;
          if (done.os != expv) begin
            m_ev[d] = 1'b1;
            if (m_err[d] < satv[d]) m_err[d]++;
            if (!m_capv[d]) begin
              m_capv[d] = 1'b1;
              m_capa[d] = done.a; m_capb[d] = done.b; m_capd[d] = done.os; m_cape[d] = expv;
            end
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    idle(1);
    for (int d = 0; d < ND; d++) begin
      checks++; if (rdy[d] !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready dut%0d got %0b want 1", d, rdy[d]); end
      checks++; if (ev[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_event dut%0d got %0b want 0", d, ev[d]); end
      checks++; if (txn[d] !== 16'd0 || err[d] !== 16'd0) begin errors++; $display("[TB] FAIL reset_counts dut%0d got txn %0d err %0d want 0 0", d, txn[d], err[d]); end
      checks++; if (sticky[d] !== 1'b0 || capv[d] !== 1'b0 || capa[d] !== '0 || cape[d] !== '0) begin
        errors++; $display("[TB] FAIL reset_capture dut%0d got sticky %0b capv %0b a %0h exp %0h want all 0", d, sticky[d], capv[d], capa[d], cape[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) step(1'b1, W'(k), W'(2 * k), W'(3 * k), 1'b0, 1'b0);
      else        idle(1);
      checks++; if (rdy[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready cyc %0d got %0b want 1", k, rdy[0]); end
      for (int d = 0; d < ND; d++) begin
        checks++; if (ev[d] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_event dut%0d cyc %0d got %0b want 0", d, k, ev[d]); end
        checks++; if (txn[d] !== 16'(m_txn[d])) begin errors++; $display("[TB] FAIL b2b_txn dut%0d cyc %0d got %0d want %0d", d, k, txn[d], m_txn[d]); end
      end
    end
    checks++; if (txn[0] !== 16'd8 || err[0] !== 16'd0) begin errors++; $display("[TB] FAIL b2b_final got txn %0d err %0d want 8 0", txn[0], err[0]); end
  endtask

  task automatic test_single_error();
    int ev0;
    do_reset();
    ev0 = ev_seen[0];
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) step(1'b1, W'(k), W'(2 * k), (k == 5) ? W'(3 * k) ^ W'(1) : W'(3 * k), 1'b0, 1'b0);
      else        idle(1);
      checks++; if (ev[0] !== (k == 7)) begin errors++; $display("[TB] FAIL single_event_timing cyc %0d got %0b want %0b", k, ev[0], k == 7); end
      for (int d = 1; d < ND; d++) begin
        checks++; if (ev[d] !== m_ev[d]) begin errors++; $display("[TB] FAIL single_event dut%0d cyc %0d got %0b want %0b", d, k, ev[d], m_ev[d]); end
      end
    end
    checks++; if (ev_seen[0] - ev0 !== 1) begin errors++; $display("[TB] FAIL single_pulses got %0d want 1", ev_seen[0] - ev0); end
    checks++; if (err[0] !== 16'd1 || sticky[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_err got err %0d sticky %0b want 1 1", err[0], sticky[0]); end
    checks++; if (capa[0] !== 32'd5 || capb[0] !== 32'd10 || capd[0] !== 32'd14 || cape[0] !== 32'd15) begin
      errors++; $display("[TB] FAIL single_capture got %0d %0d %0d %0d want 5 10 14 15", capa[0], capb[0], capd[0], cape[0]);
    end
  endtask

  task automatic test_two_errors();
    do_reset();
    for (int k = 1; k <= 8; k++)
      step(1'b1, W'(k), W'(2 * k), (k == 3 || k == 6) ? W'(3 * k) ^ W'(1) : W'(3 * k), 1'b0, 1'b0);
    idle(2);
    checks++; if (err[0] !== 16'd2) begin errors++; $display("[TB] FAIL two_err_count got %0d want 2", err[0]); end
    checks++; if (capa[0] !== 32'd3 || capb[0] !== 32'd6 || capd[0] !== 32'd8 || cape[0] !== 32'd9) begin
      errors++; $display("[TB] FAIL two_err_capture got %0d %0d %0d %0d want 3 6 8 9", capa[0], capb[0], capd[0], cape[0]);
    end
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (err[0] !== 16'd0 || txn[0] !== 16'd0 || capv[0] !== 1'b0 || sticky[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_state got err %0d txn %0d capv %0b sticky %0b want 0 0 0 0", err[0], txn[0], capv[0], sticky[0]);
    end
    step(1'b1, 32'd9, 32'd18, 32'd26, 1'b0, 1'b0);
    idle(2);
    checks++; if (capa[0] !== 32'd9 || capb[0] !== 32'd18 || capd[0] !== 32'd26 || cape[0] !== 32'd27) begin
      errors++; $display("[TB] FAIL clear_recapture got %0d %0d %0d %0d want 9 18 26 27", capa[0], capb[0], capd[0], cape[0]);
    end
    checks++; if (err[0] !== 16'd1 || txn[0] !== 16'd1 || capv[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_recount got err %0d txn %0d capv %0b want 1 1 1", err[0], txn[0], capv[0]);
    end
  endtask

  task automatic test_single_lane();
    int accepts;
    accepts = 0;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      checks++; if (rdy[1] !== (k % 2 == 1)) begin errors++; $display("[TB] FAIL one_lane_ready cyc %0d got %0b want %0b", k, rdy[1], k % 2 == 1); end
      if (rdy[1] === 1'b1) accepts++;
      step(1'b1, W'(k), W'(k), W'(2 * k), 1'b0, 1'b0);
    end
    idle(3);
    checks++; if (accepts !== 3) begin errors++; $display("[TB] FAIL one_lane_accepts got %0d want 3", accepts); end
    checks++; if (txn[1] !== 16'd3 || err[1] !== 16'd0) begin errors++; $display("[TB] FAIL one_lane_txn got txn %0d err %0d want 3 0", txn[1], err[1]); end
  endtask

  task automatic test_alternate();
    int nacc;
    logic [3:0] lane_exp;
    logic [W-1:0] x;
    nacc = 0;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      if (k % 2 == 1 && k <= 9) begin
        x = $urandom;
        lane_exp = 4'b0001 << (nacc % 4);
        step(1'b1, x, x ^ 32'h5a5a, x + (x ^ 32'h5a5a), 1'b0, 1'b0);
        nacc++;
        checks++; if (dut2.r_busy !== lane_exp) begin errors++; $display("[TB] FAIL alt_lane acc %0d got %b want %b", nacc, dut2.r_busy, lane_exp); end
      end else begin
        idle(1);
      end
      checks++; if (ev[2] !== 1'b0) begin errors++; $display("[TB] FAIL alt_event cyc %0d got %0b want 0", k, ev[2]); end
      checks++; if (txn[2] !== 16'((k - 1) / 2 > 5 ? 5 : (k - 1) / 2)) begin
        errors++; $display("[TB] FAIL alt_txn cyc %0d got %0d want %0d", k, txn[2], (k - 1) / 2 > 5 ? 5 : (k - 1) / 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 32'd7, 32'd7, 32'd15, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      for (int d = 0; d < ND; d++) begin
        checks++; if (ev[d] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_event dut%0d cyc %0d got %0b want 0", d, k, ev[d]); end
      end
    end
    for (int d = 0; d < ND; d++) begin
      checks++; if (txn[d] !== 16'd0 || err[d] !== 16'd0 || capv[d] !== 1'b0 || rdy[d] !== 1'b1) begin
        errors++; $display("[TB] FAIL midreset_state dut%0d got txn %0d err %0d capv %0b rdy %0b want 0 0 0 1", d, txn[d], err[d], capv[d], rdy[d]);
      end
    end
  endtask

  task automatic test_saturation();
    int ev3;
    logic [W-1:0] x;
    do_reset();
    ev3 = ev_seen[3];
    for (int k = 0; k < 5; k++) begin
      x = $urandom;
      step(1'b1, x, W'(k), x + W'(k) + W'(1), 1'b0, 1'b0);
    end
    idle(2);
    checks++; if (err[3] !== 16'd3 || txn[3] !== 16'd3) begin errors++; $display("[TB] FAIL sat_count got err %0d txn %0d want 3 3", err[3], txn[3]); end
    checks++; if (ev_seen[3] - ev3 !== 5) begin errors++; $display("[TB] FAIL sat_pulses got %0d want 5", ev_seen[3] - ev3); end
    checks++; if (err[0] !== 16'd5) begin errors++; $display("[TB] FAIL sat_wide_count got %0d want 5", err[0]); end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, z;
    bit v, c, r;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      x = $urandom; y = $urandom;
      z = ($urandom_range(99) < 25) ? x + y + W'($urandom_range(255, 1)) : x + y;
      v = $urandom_range(99) < 70;
      c = $urandom_range(99) < 3;
      r = $urandom_range(99) < 1;
      step(v, x, y, z, c, r);
      for (int d = 0; d < ND; d++) begin
        checks++; if (rdy[d] !== m_ready[d]) begin errors++; $display("[TB] FAIL rnd_ready dut%0d cyc %0d got %0b want %0b", d, k, rdy[d], m_ready[d]); end
        checks++; if (ev[d] !== m_ev[d]) begin errors++; $display("[TB] FAIL rnd_event dut%0d cyc %0d got %0b want %0b", d, k, ev[d], m_ev[d]); end
        checks++; if (txn[d] !== 16'(m_txn[d]) || err[d] !== 16'(m_err[d])) begin
          errors++; $display("[TB] FAIL rnd_counts dut%0d cyc %0d got %0d/%0d want %0d/%0d", d, k, txn[d], err[d], m_txn[d], m_err[d]);
        end
        checks++; if (capv[d] !== m_capv[d] || sticky[d] !== m_capv[d]) begin
          errors++; $display("[TB] FAIL rnd_flags dut%0d cyc %0d got capv %0b sticky %0b want %0b", d, k, capv[d], sticky[d], m_capv[d]);
        end
        checks++; if (capa[d] !== m_capa[d] || capb[d] !== m_capb[d] || capd[d] !== m_capd[d] || cape[d] !== m_cape[d]) begin
          errors++; $display("[TB] FAIL rnd_capture dut%0d cyc %0d got %0h %0h %0h %0h want %0h %0h %0h %0h", d, k,
                             capa[d], capb[d], capd[d], cape[d], m_capa[d], m_capb[d], m_capd[d], m_cape[d]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting monitor_rr_stats bench");
    test_reset();
    test_back_to_back();
    test_single_error();
    test_two_errors();
    test_single_lane();
    test_alternate();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
